// File: rtl/nand_pkg.sv
// Shared definitions for the NAND command path: latch encodings, sequencer
// states, error codes and default ONFI timing constants.
package nand_pkg;

  localparam logic LATCH_CMD  = 1'b0;
  localparam logic LATCH_ADDR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_NEXT,
    S_TWB,
    S_WAIT_RB,
    S_DONE
  } seq_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_LATCH_TO = 2'd1;
  localparam logic [1:0] ERR_RB_TO    = 2'd2;
  localparam logic [1:0] ERR_NADDR    = 2'd3;

  localparam int MAX_ADDR_CYCLES_DEF = 5;
  localparam int T_WB_CYC            = 10;
  localparam int BUSY_TIMEOUT_CYC    = 64;
  localparam int RB_TIMEOUT_CYC      = 65535;

  // Picks address byte i out of the 40-bit address; bytes past 4 read as zero.
  function automatic logic [7:0] addr_byte(input logic [39:0] a, input logic [2:0] i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 5; k++) begin
      if (i == 3'(k)) b = a[k*8 +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/nand_sync2.sv
// Two-flop synchroniser for the raw R/B# pin. Resets to 1 so the device
// reads as ready until the first real samples arrive.
module nand_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is used by downstream logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nand_cmd_sequencer.sv
// Drives one latch unit through CMD1, address cycles, optional CMD2 and an
// optional tWB + R/B# wait for a single host request.
//
//  state       | meaning
//  ------------+-----------------------------------------------------
//  S_IDLE      | ready for a request
//  S_ISSUE     | lu_activate pulse for the current latch
//  S_WAIT_RISE | waiting for lu_busy to go high
//  S_WAIT_FALL | waiting for lu_busy to drop (latch complete)
//  S_NEXT      | pick next latch or move to tWB / done
//  S_TWB       | counting T_WB cycles after the last latch
//  S_WAIT_RB   | waiting for synchronised R/B# high
//  S_DONE      | one-cycle done pulse, err valid
module nand_cmd_sequencer
  import nand_pkg::*;
#(
  parameter int MAX_ADDR_CYCLES = MAX_ADDR_CYCLES_DEF,
  parameter int T_WB            = T_WB_CYC,
  parameter int BUSY_TIMEOUT    = BUSY_TIMEOUT_CYC,
  parameter int RB_TIMEOUT      = RB_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd1,
  input  logic [39:0] req_addr,
  input  logic [2:0]  req_naddr,
  input  logic        req_has_cmd2,
  input  logic [7:0]  req_cmd2,
  input  logic        req_wait_rb,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic        lu_activate,
  output logic        lu_type,
  output logic [15:0] lu_data,
  input  logic        lu_busy,
  input  logic        nand_rb_n
);

  seq_state_t  state, state_nx;
  logic [15:0] tmr;
  logic [2:0]  addr_idx, addr_nx;
  logic        cmd2_sent;
  logic [39:0] addr_q;
  logic [2:0]  naddr_q;
  logic        has_cmd2_q, wait_rb_q;
  logic [7:0]  cmd2_q;
  logic        err_q;
  logic        rb_sync;
  logic        fin_err;
  logic [1:0]  fin_code;
  logic        item_type, item_cmd2;
  logic [7:0]  item_byte;

  nand_sync2 u_rb_sync (
    .clk (clk),
    .rst (rst),
    .d   (nand_rb_n),
    .q   (rb_sync)
  );

  assign req_ready   = (state == S_IDLE) && !rst;
  assign done        = (state == S_DONE);
  assign err         = done && err_q;
  assign busy        = (state != S_IDLE);
  assign lu_activate = (state == S_ISSUE);

  // Next state, the next latch item and the completion status.
  always_comb begin
    state_nx  = state;
    fin_err   = 1'b0;
    fin_code  = ERR_NONE;
    item_type = LATCH_CMD;
    item_byte = 8'h00;
    item_cmd2 = 1'b0;
    addr_nx   = addr_idx + ((lu_type == LATCH_ADDR) ? 3'd1 : 3'd0);
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_naddr > 3'(MAX_ADDR_CYCLES)) begin
            state_nx = S_DONE;
            fin_err  = 1'b1;
            fin_code = ERR_NADDR;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_nx = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (lu_busy) state_nx = S_WAIT_FALL;
        else if (tmr == 16'd0) begin
          state_nx = S_DONE;
          fin_err  = 1'b1;
          fin_code = ERR_LATCH_TO;
        end
      end
      S_WAIT_FALL: begin
        if (!lu_busy) state_nx = S_NEXT;
        else if (tmr == 16'd0) begin
          state_nx = S_DONE;
          fin_err  = 1'b1;
          fin_code = ERR_LATCH_TO;
        end
      end
      S_NEXT: begin
        if (addr_nx < naddr_q) begin
          state_nx  = S_ISSUE;
          item_type = LATCH_ADDR;
          item_byte = addr_byte(addr_q, addr_nx);
        end else if (has_cmd2_q && !cmd2_sent) begin
          state_nx  = S_ISSUE;
          item_byte = cmd2_q;
          item_cmd2 = 1'b1;
        end else if (wait_rb_q) begin
          state_nx = S_TWB;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_TWB: if (tmr == 16'd0) state_nx = S_WAIT_RB;
      S_WAIT_RB: begin
        if (rb_sync) state_nx = S_DONE;
        else if (tmr == 16'd0) begin
          state_nx = S_DONE;
          fin_err  = 1'b1;
          fin_code = ERR_RB_TO;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, timeout down-counter (reloaded on every state entry) and request context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tmr        <= 16'd0;
      addr_idx   <= 3'd0;
      cmd2_sent  <= 1'b0;
      addr_q     <= 40'd0;
      naddr_q    <= 3'd0;
      has_cmd2_q <= 1'b0;
      cmd2_q     <= 8'h00;
      wait_rb_q  <= 1'b0;
      lu_type    <= LATCH_CMD;
      lu_data    <= 16'h0000;
      err_q      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        case (state_nx)
          S_WAIT_RISE, S_WAIT_FALL: tmr <= 16'(BUSY_TIMEOUT);
          S_TWB:                    tmr <= 16'(T_WB - 1);
          S_WAIT_RB:                tmr <= 16'(RB_TIMEOUT);
          default:                  tmr <= 16'd0;
        endcase
      end else if (tmr != 16'd0) begin
        tmr <= tmr - 16'd1;
      end
      if (state == S_IDLE && req_valid) begin
        addr_q     <= req_addr;
        naddr_q    <= req_naddr;
        has_cmd2_q <= req_has_cmd2;
        cmd2_q     <= req_cmd2;
        wait_rb_q  <= req_wait_rb;
        addr_idx   <= 3'd0;
        cmd2_sent  <= 1'b0;
        err_q      <= fin_err;
        err_code   <= fin_code;
        if (state_nx == S_ISSUE) begin
          lu_type <= LATCH_CMD;
          lu_data <= {8'h00, req_cmd1};
        end
      end else if (state_nx == S_DONE && state != S_DONE) begin
        err_q    <= fin_err;
        err_code <= fin_code;
      end
      if (state == S_NEXT) begin
        addr_idx <= addr_nx;
        if (state_nx == S_ISSUE) begin
          lu_type <= item_type;
          lu_data <= {8'h00, item_byte};
          if (item_cmd2) cmd2_sent <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// Self-checking bench: behavioural latch-unit model on the lu_* ports and a
// request-level reference that lists the latches each request should produce.
module tb_nand_cmd_sequencer;
  import nand_pkg::*;

  localparam int P_MAXA = 5;
  localparam int P_TWB  = 10;
  localparam int P_BTO  = 64;
  localparam int P_RBTO = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd1;
  logic [39:0] req_addr;
  logic [2:0]  req_naddr;
  logic        req_has_cmd2;
  logic [7:0]  req_cmd2;
  logic        req_wait_rb;
  logic        done, err, busy, lu_activate, lu_type, lu_busy, nand_rb_n;
  logic [1:0]  err_code;
  logic [15:0] lu_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic        stuck = 1'b0;
  logic        lu_type_q[$];
  logic [15:0] lu_data_q[$];
  logic [16:0] exp_q[$];

  nand_cmd_sequencer #(
    .MAX_ADDR_CYCLES (P_MAXA),
    .T_WB            (P_TWB),
    .BUSY_TIMEOUT    (P_BTO),
    .RB_TIMEOUT      (P_RBTO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd1     (req_cmd1),
    .req_addr     (req_addr),
    .req_naddr    (req_naddr),
    .req_has_cmd2 (req_has_cmd2),
    .req_cmd2     (req_cmd2),
    .req_wait_rb  (req_wait_rb),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .busy         (busy),
    .lu_activate  (lu_activate),
    .lu_type      (lu_type),
    .lu_data      (lu_data),
    .lu_busy      (lu_busy),
    .nand_rb_n    (nand_rb_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Latch unit model: busy rises 1-2 cycles after activate, stays high 1-6 cycles.
  logic        m_type, m_rhit;
  logic [15:0] m_data;
  int          m_rise, m_dur;
  initial begin
    lu_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (lu_activate) begin
        lu_type_q.push_back(lu_type);
        lu_data_q.push_back(lu_data);
        if (!stuck) begin
          m_rhit = 1'b0;
          m_type = lu_type;
          m_data = lu_data;
          m_rise = $urandom_range(0, 1);
          m_dur  = $urandom_range(1, 6);
          @(posedge clk);
          repeat (m_rise) @(posedge clk);
          #1 lu_busy = 1'b1;
          repeat (m_dur) begin
            @(posedge clk);
            if (rst) m_rhit = 1'b1;
          end
          #1 lu_busy = 1'b0;
          if (!m_rhit && !rst) chk("lu_stable", {m_type, m_data}, {lu_type, lu_data});
        end
      end
    end
  end

  // Activate must never coincide with lu_busy nor repeat on consecutive cycles.
  logic prev_act = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (lu_activate) chk("act_rule", {prev_act, lu_busy}, 2'b00);
      prev_act = lu_activate;
    end
  end

  // Reference: the ordered latch list a request must produce.
  task automatic build_exp(input logic [7:0] c1, input logic [39:0] a, input logic [2:0] n,
                           input logic h2, input logic [7:0] c2);
    exp_q.delete();
    if (int'(n) <= P_MAXA) begin
      exp_q.push_back({LATCH_CMD, 8'h00, c1});
      for (int i = 0; i < int'(n); i++) exp_q.push_back({LATCH_ADDR, 8'h00, a[i*8 +: 8]});
      if (h2) exp_q.push_back({LATCH_CMD, 8'h00, c2});
    end
  endtask

  task automatic cmp_latches(input string tag);
    chk({tag, "_nlatch"}, 64'(lu_data_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < lu_data_q.size(); i++)
      chk($sformatf("%s_latch%0d", tag, i), {lu_type_q[i], lu_data_q[i]}, exp_q[i]);
  endtask

  task automatic run_req(input logic [7:0] c1, input logic [39:0] a, input logic [2:0] n,
                         input logic h2, input logic [7:0] c2, input logic wrb,
                         input int rb_lo, input int budget,
                         output logic ok, output logic e, output logic [1:0] code,
                         output int d_cyc, output int act_cyc, output int rbh_cyc);
    int rbc;
    lu_type_q.delete();
    lu_data_q.delete();
    ok = 1'b0; e = 1'b0; code = 2'd0; d_cyc = -1; act_cyc = -1; rbh_cyc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_cmd1 = c1; req_addr = a; req_naddr = n;
    req_has_cmd2 = h2; req_cmd2 = c2; req_wait_rb = wrb;
    chk("ready_at_req", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_cmd1 = 8'($urandom); req_addr = {8'($urandom), 32'($urandom)};
    req_naddr = 3'($urandom); req_has_cmd2 = 1'($urandom);
    req_cmd2 = 8'($urandom); req_wait_rb = 1'($urandom);
    rbc = wrb ? rb_lo : 0;
    if (rbc > 0) nand_rb_n = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (rbc > 0) begin
        rbc--;
        if (rbc == 0) begin
          nand_rb_n = 1'b1;
          rbh_cyc = c;
        end
      end
      if (lu_activate && act_cyc < 0) act_cyc = c;
      if (done) begin
        ok = 1'b1; e = err; code = err_code; d_cyc = c;
        break;
      end
    end
    nand_rb_n = 1'b1;
    chk("done_seen", ok, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ready_back", req_ready, 1);
  endtask

  logic       ok, e;
  logic [1:0] code;
  int         d_cyc, act_cyc, rbh_cyc, n_act;
  logic       saw_done;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_cmd1 = 8'h00; req_addr = 40'd0; req_naddr = 3'd0;
    req_has_cmd2 = 1'b0; req_cmd2 = 8'h00; req_wait_rb = 1'b0; nand_rb_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_outs", {done, err, busy, lu_activate, err_code, lu_type, lu_data}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // Read page
    build_exp(8'h00, 40'h0403020100, 3'd5, 1'b1, 8'h30);
    run_req(8'h00, 40'h0403020100, 3'd5, 1'b1, 8'h30, 1'b1, 200, 2000,
            ok, e, code, d_cyc, act_cyc, rbh_cyc);
    chk("rd_err", {e, code}, 3'b000);
    cmp_latches("rd");
    chk("rd_after_rb", (rbh_cyc > 0 && d_cyc >= rbh_cyc + 2), 1);

    // Reset command
    build_exp(8'hFF, 40'd0, 3'd0, 1'b0, 8'h00);
    run_req(8'hFF, 40'd0, 3'd0, 1'b0, 8'h00, 1'b0, 0, 500, ok, e, code, d_cyc, act_cyc, rbh_cyc);
    chk("rstcmd_err", {e, code}, 3'b000);
    cmp_latches("rstcmd");

    // Bad address count
    build_exp(8'h80, 40'h1, 3'd6, 1'b1, 8'h10);
    run_req(8'h80, 40'h1, 3'd6, 1'b1, 8'h10, 1'b0, 0, 50, ok, e, code, d_cyc, act_cyc, rbh_cyc);
    chk("naddr_err", {e, code}, {1'b1, ERR_NADDR});
    chk("naddr_lat", d_cyc, 1);
    cmp_latches("naddr");

    // Latch unit never responds
    stuck = 1'b1;
    run_req(8'h70, 40'h0, 3'd2, 1'b0, 8'h00, 1'b0, 0, 500, ok, e, code, d_cyc, act_cyc, rbh_cyc);
    chk("lto_err", {e, code}, {1'b1, ERR_LATCH_TO});
    chk("lto_time", (act_cyc > 0 && d_cyc - act_cyc >= P_BTO && d_cyc - act_cyc <= P_BTO + 4), 1);
    repeat (10) @(negedge clk);
    chk("lto_nact", 64'(lu_data_q.size()), 64'd1);
    stuck = 1'b0;

    // R/B# held low past the timeout
    run_req(8'h60, 40'h0, 3'd0, 1'b0, 8'h00, 1'b1, P_TWB + P_RBTO + 200, 1000,
            ok, e, code, d_cyc, act_cyc, rbh_cyc);
    chk("rbto_err", {e, code}, {1'b1, ERR_RB_TO});
    chk("rbto_time", (d_cyc >= P_TWB + P_RBTO && d_cyc <= P_TWB + P_RBTO + 40), 1);

    // Reset during the third address latch
    lu_type_q.delete();
    lu_data_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_cmd1 = 8'h00; req_addr = 40'h0403020100; req_naddr = 3'd5;
    req_has_cmd2 = 1'b1; req_cmd2 = 8'h30; req_wait_rb = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (lu_data_q.size() >= 4 && lu_busy) break;
    end
    chk("rst_at_addr3", (lu_data_q.size() == 4 && lu_busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", {done, err, busy, lu_activate, err_code, lu_type, lu_data}, 0);
    chk("abort_ready", req_ready, 0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    build_exp(8'hFF, 40'd0, 3'd0, 1'b0, 8'h00);
    run_req(8'hFF, 40'd0, 3'd0, 1'b0, 8'h00, 1'b0, 0, 500, ok, e, code, d_cyc, act_cyc, rbh_cyc);
    chk("after_abort_err", {e, code}, 3'b000);
    cmp_latches("after_abort");

    // Randomised requests
    for (int k = 0; k < 14; k++) begin
      logic [7:0]  rc1, rc2;
      logic [39:0] ra;
      logic [2:0]  rn;
      logic        rh, rw;
      int          rl;
      rc1 = 8'($urandom); rc2 = 8'($urandom);
      ra  = {8'($urandom), 32'($urandom)};
      rn  = 3'($urandom_range(0, 7));
      rh  = 1'($urandom); rw = 1'($urandom);
      rl  = rw ? $urandom_range(0, 100) : 0;
      build_exp(rc1, ra, rn, rh, rc2);
      run_req(rc1, ra, rn, rh, rc2, rw, rl, 2000, ok, e, code, d_cyc, act_cyc, rbh_cyc);
      if (int'(rn) > P_MAXA) chk($sformatf("rnd%0d_err", k), {e, code}, {1'b1, ERR_NADDR});
      else                   chk($sformatf("rnd%0d_err", k), {e, code}, 3'b000);
      cmp_latches($sformatf("rnd%0d", k));
      if (rw && rl > 0 && int'(rn) <= P_MAXA)
        chk($sformatf("rnd%0d_after_rb", k), (d_cyc >= rbh_cyc + 2 && rbh_cyc > 0), 1);
    end

    n_act = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
